systolic_config_regs: RTL and testbench



---
 rtl/systolic_cfg_pkg.sv | 28 ++
 rtl/systolic_config_regs.sv | 155 +++++++++++++++
 tb/tb_systolic_config_regs.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_cfg_pkg.sv
// Register indices, CTRL/STATUS bit positions and FSM encoding shared by the
// systolic array configuration front end and anything that talks to it.
package systolic_cfg_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_M        = 2;
  localparam int unsigned REG_N        = 3;
  localparam int unsigned REG_P        = 4;
  localparam int unsigned REG_BASE_A   = 5;
  localparam int unsigned REG_BASE_B   = 6;
  localparam int unsigned REG_BASE_C   = 7;
  localparam int unsigned REG_OP_COUNT = 8;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/systolic_config_regs.sv
// Config/control registers for systolic_array_top: locks dims while busy, stretches start, tracks done.
// Writes land on the sampling edge, reads return one cycle after cfg_re; no backpressure, the bus never stalls.
module systolic_config_regs
  import systolic_cfg_pkg::*;
#(
  parameter int START_HOLD = 4,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              cfg_rvalid,
  output logic [15:0]       m,
  output logic [15:0]       n,
  output logic [15:0]       p,
  output logic [15:0]       base_addr_a,
  output logic [15:0]       base_addr_b,
  output logic [15:0]       base_addr_c,
  output logic              start_o,
  input  logic              operation_done,
  output logic              irq_o
);

  localparam int CW = $clog2(START_HOLD + 1);

  cfg_state_t  state;
  logic [CW-1:0] hold_cnt;
  logic        irq_en;
  logic        done_flag;
  logic        err_flag;
  logic [15:0] op_count;
  logic        done_q;

  logic        busy;
  logic        sel_ctrl;
  logic        sel_status;
  logic        dim_we;
  logic        start_req;
  logic        dims_ok;
  logic        go;
  logic        err_set;
  logic        done_rise;
  logic [15:0] rd_mux;

  always_comb begin
    busy       = (state != ST_IDLE);
    sel_ctrl   = cfg_we && (cfg_addr == ADDR_W'(REG_CTRL));
    sel_status = cfg_we && (cfg_addr == ADDR_W'(REG_STATUS));
    dim_we     = cfg_we && (cfg_addr >= ADDR_W'(REG_M)) && (cfg_addr <= ADDR_W'(REG_BASE_C));
    start_req  = sel_ctrl && cfg_wdata[CTRL_START];
    dims_ok    = (m != 16'd0) && (n != 16'd0) && (p != 16'd0);
    go         = start_req && !busy && dims_ok;
    err_set    = (start_req && (busy || !dims_ok)) || (dim_we && busy);
    // Compare against last cycle's level so a level left high from a previous op is not a new completion.
    done_rise  = (state == ST_RUN) && operation_done && !done_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (go) state <= ST_START;
        end
        ST_START: begin
          if (hold_cnt == CW'(START_HOLD - 1)) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (done_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en      <= 1'b0;
      done_flag   <= 1'b0;
      err_flag    <= 1'b0;
      op_count    <= 16'd0;
      done_q      <= 1'b0;
      m           <= 16'd0;
      n           <= 16'd0;
      p           <= 16'd0;
      base_addr_a <= 16'd0;
      base_addr_b <= 16'd0;
      base_addr_c <= 16'd0;
    end else begin
      done_q <= operation_done;
      if (sel_ctrl) irq_en <= cfg_wdata[CTRL_IRQ_EN];
      // Set events beat a same-cycle write-1-to-clear; each bit resolves independently.
      done_flag <= done_rise || (done_flag && !(sel_status && cfg_wdata[STAT_DONE]));
      err_flag  <= err_set   || (err_flag  && !(sel_status && cfg_wdata[STAT_ERR]));
      if (done_rise) op_count <= op_count + 16'd1;
      if (dim_we && !busy) begin
        case (cfg_addr)
          ADDR_W'(REG_M):      m           <= cfg_wdata;
          ADDR_W'(REG_N):      n           <= cfg_wdata;
          ADDR_W'(REG_P):      p           <= cfg_wdata;
          ADDR_W'(REG_BASE_A): base_addr_a <= cfg_wdata;
          ADDR_W'(REG_BASE_B): base_addr_b <= cfg_wdata;
          ADDR_W'(REG_BASE_C): base_addr_c <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = 16'd0;
    case (cfg_addr)
      ADDR_W'(REG_CTRL):     rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_W'(REG_STATUS): begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done_flag;
        rd_mux[STAT_ERR]  = err_flag;
      end
      ADDR_W'(REG_M):        rd_mux = m;
      ADDR_W'(REG_N):        rd_mux = n;
      ADDR_W'(REG_P):        rd_mux = p;
      ADDR_W'(REG_BASE_A):   rd_mux = base_addr_a;
      ADDR_W'(REG_BASE_B):   rd_mux = base_addr_b;
      ADDR_W'(REG_BASE_C):   rd_mux = base_addr_c;
      ADDR_W'(REG_OP_COUNT): rd_mux = op_count;
      default:               rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_rdata  <= 16'd0;
      cfg_rvalid <= 1'b0;
    end else begin
      cfg_rvalid <= cfg_re;
      cfg_rdata  <= cfg_re ? rd_mux : 16'd0;
    end
  end

  assign start_o = (state == ST_START);
  assign irq_o   = irq_en && (done_flag || err_flag);

endmodule

// File: tb/tb_systolic_config_regs.sv
// Directed bench for systolic_config_regs: each task drives a scenario and checks against hand-computed values.
module tb_systolic_config_regs;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic        cfg_re;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        cfg_rvalid;
  logic [15:0] m, n, p, base_addr_a, base_addr_b, base_addr_c;
  logic        start_o;
  logic        operation_done;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  systolic_config_regs #(.START_HOLD(4), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .m(m), .n(n), .p(p),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .base_addr_c(base_addr_c),
    .start_o(start_o), .operation_done(operation_done), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d, output logic v);
    @(negedge clk);
    cfg_re = 1'b1; cfg_addr = a;
    @(negedge clk);
    cfg_re = 1'b0;
    d = cfg_rdata; v = cfg_rvalid;
  endtask

  task automatic pulse_done();
    @(negedge clk); operation_done = 1'b1;
    @(negedge clk); operation_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op();
    wr(4'd0, 16'h0001);
    repeat (8) @(negedge clk);
    pulse_done();
  endtask

  task automatic test_reset();
    logic [15:0] d; logic v;
    checks++; if (start_o !== 1'b0 || irq_o !== 1'b0 || cfg_rvalid !== 1'b0 || cfg_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_outputs start=%b irq=%b rvalid=%b rdata=%h want 0", start_o, irq_o, cfg_rvalid, cfg_rdata);
    end
    for (int a = 0; a <= 9; a++) begin
      logic [3:0] addr;
      addr = (a == 9) ? 4'd15 : 4'(a);
      rd(addr, d, v);
      checks++; if (d !== 16'h0 || v !== 1'b1) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h valid=%b want 0000 valid 1", addr, d, v);
      end
    end
  endtask

  task automatic test_basic_op();
    logic [15:0] d; logic v; int cnt;
    wr(4'd2, 16'd4); wr(4'd3, 16'd8); wr(4'd4, 16'd32);
    checks++; if (m !== 16'd4 || n !== 16'd8 || p !== 16'd32) begin
      errors++; $display("FAIL dim_outputs m=%0d n=%0d p=%0d want 4 8 32", m, n, p);
    end
    wr(4'd0, 16'h0003);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (start_o) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 4) begin
      errors++; $display("FAIL start_width got=%0d cycles want 4", cnt);
    end
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0001) begin
      errors++; $display("FAIL busy_in_run status=%h want 0001", d);
    end
    pulse_done();
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0002) begin
      errors++; $display("FAIL status_done got=%h want 0002", d);
    end
    rd(4'd8, d, v);
    checks++; if (d !== 16'h0001) begin
      errors++; $display("FAIL op_count_1 got=%h want 0001", d);
    end
    checks++; if (irq_o !== 1'b1) begin
      errors++; $display("FAIL irq_done got=%b want 1", irq_o);
    end
    wr(4'd1, 16'h0002);
    checks++; if (irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_after_w1c got=%b want 0", irq_o);
    end
  endtask

  task automatic test_zero_dim();
    logic [15:0] d; logic v; int cnt;
    wr(4'd4, 16'd0);
    wr(4'd0, 16'h0003);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (start_o) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 0) begin
      errors++; $display("FAIL zero_dim_start got=%0d cycles want 0", cnt);
    end
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0004) begin
      errors++; $display("FAIL zero_dim_status got=%h want 0004", d);
    end
    wr(4'd1, 16'h0004);
    wr(4'd4, 16'd32);
  endtask

  task automatic test_locked_write();
    logic [15:0] d; logic v;
    wr(4'd0, 16'h0003);
    repeat (6) @(negedge clk);
    wr(4'd2, 16'd7);
    wr(4'd0, 16'h0003);
    rd(4'd2, d, v);
    checks++; if (d !== 16'd4 || m !== 16'd4) begin
      errors++; $display("FAIL locked_m read=%0d out=%0d want 4", d, m);
    end
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0005) begin
      errors++; $display("FAIL locked_status got=%h want 0005", d);
    end
    // Completion edge and a W1C of DONE|ERR in the same cycle: DONE set wins, ERR clears.
    @(negedge clk);
    operation_done = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 16'h0006;
    @(negedge clk);
    cfg_we = 1'b0; operation_done = 1'b0;
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0002) begin
      errors++; $display("FAIL set_beats_w1c status=%h want 0002", d);
    end
    rd(4'd8, d, v);
    checks++; if (d !== 16'h0002) begin
      errors++; $display("FAIL op_count_2 got=%h want 0002", d);
    end
    wr(4'd1, 16'h0006);
  endtask

  task automatic test_stale_done();
    logic [15:0] d; logic v;
    operation_done = 1'b1;
    repeat (2) @(negedge clk);
    wr(4'd0, 16'h0001);
    repeat (12) @(negedge clk);
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0001) begin
      errors++; $display("FAIL stale_done_status got=%h want 0001", d);
    end
    @(negedge clk); operation_done = 1'b0;
    @(negedge clk); operation_done = 1'b1;
    @(negedge clk); operation_done = 1'b0;
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0002) begin
      errors++; $display("FAIL stale_done_complete got=%h want 0002", d);
    end
    rd(4'd8, d, v);
    checks++; if (d !== 16'h0003) begin
      errors++; $display("FAIL op_count_3 got=%h want 0003", d);
    end
    wr(4'd1, 16'h0002);
  endtask

  task automatic test_rw_same_cycle();
    logic [15:0] d;
    @(negedge clk);
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'hABCD;
    @(negedge clk);
    cfg_we = 1'b0; cfg_re = 1'b0;
    d = cfg_rdata;
    checks++; if (d !== 16'h0000) begin
      errors++; $display("FAIL rw_old_value got=%h want 0000", d);
    end
    checks++; if (base_addr_a !== 16'hABCD) begin
      errors++; $display("FAIL rw_new_value got=%h want abcd", base_addr_a);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d; logic v;
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    @(negedge clk);
    release dut.op_count;
    run_op();
    rd(4'd8, d, v);
    checks++; if (d !== 16'hFFFF) begin
      errors++; $display("FAIL count_ffff got=%h want ffff", d);
    end
    run_op();
    rd(4'd8, d, v);
    checks++; if (d !== 16'h0000) begin
      errors++; $display("FAIL count_wrap got=%h want 0000", d);
    end
  endtask

  task automatic test_reset_mid_start();
    logic [15:0] d; logic v;
    wr(4'd0, 16'h0003);
    checks++; if (start_o !== 1'b1) begin
      errors++; $display("FAIL start_before_reset got=%b want 1", start_o);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (start_o !== 1'b0 || irq_o !== 1'b0 || m !== 16'd0 || base_addr_a !== 16'd0) begin
      errors++; $display("FAIL async_reset start=%b irq=%b m=%h base_a=%h want 0", start_o, irq_o, m, base_addr_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd1, d, v);
    checks++; if (d !== 16'h0000) begin
      errors++; $display("FAIL status_after_reset got=%h want 0000", d);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 4'd0; cfg_wdata = 16'h0;
    operation_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_basic_op();
    test_zero_dim();
    test_locked_write();
    test_stale_done();
    test_rw_same_cycle();
    test_wrap();
    test_reset_mid_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
